// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32M multiply/divide unit that sits in EX beside the ALU.
// Radix-2 shift-add multiplier and restoring divider sharing one XLEN+1-bit adder.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start         request, sampled only in IDLE
//   func3         MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
//   rs1, rs2      operands, captured on the start edge
//   flush         abort the in-flight op
//   busy          high in PREP, CALC and FIX
//   stall         holds the pipeline: start in IDLE, or busy
//   done          1-cycle pulse, result valid
//   result        registered, held until the next done
//   illegal       pulses with done for an unsupported op
//
// Build option MULDIV_DIV_EN: when defined, the divide ops are implemented.
// When undefined, divide ops finish at once with result 0 and illegal set.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  localparam int CW = $clog2(XLEN) + 1;

`ifdef MULDIV_DIV_EN
  localparam logic HAS_DIV = 1'b1;
`else
  localparam logic HAS_DIV = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [2:0]      op;
  logic [XLEN:0]   hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] opb;
  logic [CW-1:0]   cnt;
  logic            neg_q;

  // operand signedness and magnitudes, valid in PREP
  logic            sgn_a, sgn_b;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b;

  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    unique case (1'b1)
      op[2]: begin
        sgn_a = ~op[0];
        sgn_b = ~op[0];
      end
      op == 3'b001: begin
        sgn_a = 1'b1;
        sgn_b = 1'b1;
      end
      op == 3'b010: begin
        sgn_a = 1'b1;
      end
      default: ;
    endcase
  end

  assign a_neg = sgn_a & lo[XLEN-1];
  assign b_neg = sgn_b & opb[XLEN-1];
  assign mag_a = a_neg ? (~lo + 1'b1) : lo;
  assign mag_b = b_neg ? (~opb + 1'b1) : opb;

  // shared adder
  logic [XLEN:0] add_a, add_b, add_s;

`ifdef MULDIV_DIV_EN
  logic            neg_r;
  logic            special;
  logic [XLEN-1:0] preset;
  logic            div_zero, div_ovf;
  logic            special_nx;
  logic            add_ci, add_co;
  logic [XLEN:0]   shifted;

  // lo and opb still hold the raw operands while in PREP
  assign div_zero = op[2] & (opb == '0);
  assign div_ovf = op[2] & ~op[0]
                 & (lo == {1'b1, {(XLEN-1){1'b0}}})
                 & (&opb);
  assign special_nx = div_zero | div_ovf;
  assign shifted = {hi[XLEN-1:0], lo[XLEN-1]};
`else
  logic special_nx;
  assign special_nx = 1'b0;
`endif

  always_comb begin
    add_a = hi;
    add_b = lo[0] ? {1'b0, opb} : '0;
`ifdef MULDIV_DIV_EN
    add_ci = 1'b0;
    // trial subtract: carry out means partial remainder >= divisor
    if (op[2]) begin
      add_a  = shifted;
      add_b  = ~{1'b0, opb};
      add_ci = 1'b1;
    end
`endif
  end

`ifdef MULDIV_DIV_EN
  assign {add_co, add_s} = {1'b0, add_a}
                         + {1'b0, add_b}
                         + {{(XLEN+1){1'b0}}, add_ci};
`else
  assign add_s = add_a + add_b;
`endif

  // multiply step: shift {sum, multiplier} right by one
  logic [XLEN:0]   mul_hi;
  logic [XLEN-1:0] mul_lo;

  assign mul_hi = {1'b0, add_s[XLEN:1]};
  assign mul_lo = {add_s[0], lo[XLEN-1:1]};

  // final result selection
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   fix_res;

  assign prod = {hi[XLEN-1:0], lo};
  assign prod_s = neg_q ? (~prod + 1'b1) : prod;

  always_comb begin
    fix_res = prod_s[2*XLEN-1:XLEN];
    if (op[1:0] == 2'b00) fix_res = prod_s[XLEN-1:0];
`ifdef MULDIV_DIV_EN
    if (op[2]) begin
      if (op[1]) begin
        fix_res = neg_r ? (~hi[XLEN-1:0] + 1'b1) : hi[XLEN-1:0];
      end else begin
        fix_res = neg_q ? (~lo + 1'b1) : lo;
      end
      if (special) fix_res = preset;
    end
`endif
  end

  // next state
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = (!HAS_DIV && func3[2]) ? DONE : PREP;
        end
      end
      PREP: state_nx = special_nx ? FIX : CALC;
      CALC: if (cnt == CW'(1)) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  assign busy = (state == PREP) | (state == CALC) | (state == FIX);
  assign stall = (start & (state == IDLE)) | busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      result  <= '0;
      done    <= 1'b0;
      illegal <= 1'b0;
      op      <= '0;
      hi      <= '0;
      lo      <= '0;
      opb     <= '0;
      neg_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
      neg_r   <= 1'b0;
      special <= 1'b0;
      preset  <= '0;
`endif
    end else begin
      state   <= state_nx;
      done    <= (state_nx == DONE);
      illegal <= 1'b0;
      unique case (state)
        IDLE: begin
          op  <= func3;
          lo  <= rs1;
          opb <= rs2;
          if (state_nx == DONE) begin
            result  <= '0;
            illegal <= 1'b1;
          end
        end
        PREP: begin
          hi    <= '0;
          lo    <= mag_a;
          opb   <= mag_b;
          neg_q <= a_neg ^ b_neg;
          cnt   <= CW'(XLEN);
`ifdef MULDIV_DIV_EN
          neg_r   <= a_neg;
          special <= special_nx;
          if (div_zero) begin
            preset <= op[1] ? lo : '1;
          end else begin
            preset <= op[1] ? '0 : lo;
          end
`endif
        end
        CALC: begin
          cnt <= cnt - 1'b1;
`ifdef MULDIV_DIV_EN
          if (op[2]) begin
            if (add_co) begin
              hi <= add_s;
              lo <= {lo[XLEN-2:0], 1'b1};
            end else begin
              hi <= shifted;
              lo <= {lo[XLEN-2:0], 1'b0};
            end
          end else begin
            hi <= mul_hi;
            lo <= mul_lo;
          end
`else
          hi <= mul_hi;
          lo <= mul_lo;
`endif
        end
        FIX: begin
          if (state_nx == DONE) result <= fix_res;
        end
        default: ;
      endcase
    end
  end

endmodule
